// File: rtl/round_timer_ctrl_if.sv
// Controller <-> game logic / counter datapath bundle for the round timer.
interface round_timer_ctrl_if;
  logic       start;
  logic       pause;
  logic       stop;
  logic [8:0] cnt;
  logic       cnt_en;
  logic       cnt_up;
  logic       cnt_load;
  logic [8:0] cnt_load_value;
  logic [8:0] cnt_max;
  logic [8:0] cnt_min;
  logic       busy;
  logic       timeout;
  logic [2:0] state;

  modport master (
    output start, pause, stop, cnt,
    input  cnt_en, cnt_up, cnt_load, cnt_load_value, cnt_max, cnt_min,
           busy, timeout, state
  );

  modport slave (
    input  start, pause, stop, cnt,
    output cnt_en, cnt_up, cnt_load, cnt_load_value, cnt_max, cnt_min,
           busy, timeout, state
  );
endinterface

// File: rtl/round_timer_ctrl.sv
// Round timer sequencer: loads an external up/down counter, paces it with a
// clock-divided tick and flags the end of the round.
module round_timer_ctrl #(
  parameter int         TICK_DIV   = 100000000,
  parameter int         PRESC_W    = 27,
  parameter logic [8:0] INIT_VALUE = 9'd60,
  parameter logic [8:0] END_VALUE  = 9'd0,
  parameter int         LOAD_HOLD  = 3
) (
  input logic              clk,
  input logic              rst,
  round_timer_ctrl_if.slave bus
);
  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] LOAD   = 3'd1;
  localparam logic [2:0] RUN    = 3'd2;
  localparam logic [2:0] PAUSED = 3'd3;
  localparam logic [2:0] DONE   = 3'd4;
  localparam int         LW     = $clog2(LOAD_HOLD + 1);

  logic [2:0]         st, nxt, prev_st;
  logic [PRESC_W-1:0] presc;
  logic [LW-1:0]      lcnt;
  logic               tick, at_end;

  assign tick   = (presc == PRESC_W'(TICK_DIV - 1));
  assign at_end = (bus.cnt == END_VALUE);

  // Static counter configuration, independent of reset.
  assign bus.cnt_up         = (END_VALUE > INIT_VALUE);
  assign bus.cnt_load_value = INIT_VALUE;
  assign bus.cnt_max        = (INIT_VALUE > END_VALUE) ? INIT_VALUE : END_VALUE;
  assign bus.cnt_min        = (INIT_VALUE > END_VALUE) ? END_VALUE : INIT_VALUE;
  assign bus.state          = st;

  always_ff @(posedge clk) begin
    if (rst) begin
      st      <= IDLE;
      prev_st <= IDLE;
      presc   <= '0;
      lcnt    <= '0;
    end else begin
      st      <= nxt;
      prev_st <= st;
      lcnt    <= (st == LOAD && nxt == LOAD) ? lcnt + LW'(1) : '0;
      // Prescaler runs only in RUN, freezes in PAUSED, restarts from 0 otherwise.
      if (st == RUN)
        presc <= tick ? '0 : presc + PRESC_W'(1);
      else if (st != PAUSED)
        presc <= '0;
    end
  end

  always_comb begin
    nxt = IDLE;
    if (!bus.stop) begin
      case (st)
        IDLE:    nxt = bus.start ? LOAD : IDLE;
        LOAD:    nxt = (lcnt == LW'(LOAD_HOLD - 1)) ? RUN : LOAD;
        RUN:     if (bus.start)      nxt = LOAD;
                 else if (at_end)    nxt = DONE;
                 else if (bus.pause) nxt = PAUSED;
                 else                nxt = RUN;
        PAUSED:  if (bus.start)      nxt = LOAD;
                 else if (bus.pause) nxt = PAUSED;
                 else                nxt = RUN;
        DONE:    nxt = bus.start ? LOAD : DONE;
        default: nxt = IDLE;
      endcase
    end
  end

  // Strobes are cut in the same cycle stop is seen so the abort is immediate.
  always_comb begin
    bus.cnt_en   = (st == RUN) && tick && !at_end && !bus.stop;
    bus.cnt_load = (st == LOAD) && !bus.stop;
    bus.busy     = (st == LOAD) || (st == RUN) || (st == PAUSED);
    bus.timeout  = (st == DONE) && (prev_st != DONE);
  end
endmodule

// File: tb/tb_round_timer_ctrl.sv
// Directed and randomized checks of round_timer_ctrl against a round-level model.
module tb_round_timer_ctrl;
  localparam int TICK = 4;
  localparam int LH   = 3;
  localparam int ENDV = 0;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  round_timer_ctrl_if b0 ();
  round_timer_ctrl_if b1 ();
  round_timer_ctrl_if b2 ();

  round_timer_ctrl #(.TICK_DIV(TICK), .PRESC_W(3), .INIT_VALUE(9'd3), .END_VALUE(9'd0),
                     .LOAD_HOLD(LH)) d0 (.clk(clk), .rst(rst), .bus(b0));
  round_timer_ctrl #(.TICK_DIV(TICK), .PRESC_W(3), .INIT_VALUE(9'd5), .END_VALUE(9'd5),
                     .LOAD_HOLD(LH)) d1 (.clk(clk), .rst(rst), .bus(b1));
  round_timer_ctrl #(.TICK_DIV(TICK), .PRESC_W(3), .INIT_VALUE(9'd0), .END_VALUE(9'd9),
                     .LOAD_HOLD(LH)) d2 (.clk(clk), .rst(rst), .bus(b2));

  // Behavioural counter datapaths with clamping.
  always @(posedge clk) begin
    if (rst) begin
      b0.cnt <= 9'd0; b1.cnt <= 9'd0; b2.cnt <= 9'd0;
    end else begin
      if (b0.cnt_load) b0.cnt <= b0.cnt_load_value;
      else if (b0.cnt_en) b0.cnt <= b0.cnt_up ? (b0.cnt < b0.cnt_max ? b0.cnt + 9'd1 : b0.cnt)
                                              : (b0.cnt > b0.cnt_min ? b0.cnt - 9'd1 : b0.cnt);
      if (b1.cnt_load) b1.cnt <= b1.cnt_load_value;
      else if (b1.cnt_en) b1.cnt <= b1.cnt_up ? (b1.cnt < b1.cnt_max ? b1.cnt + 9'd1 : b1.cnt)
                                              : (b1.cnt > b1.cnt_min ? b1.cnt - 9'd1 : b1.cnt);
      if (b2.cnt_load) b2.cnt <= b2.cnt_load_value;
      else if (b2.cnt_en) b2.cnt <= b2.cnt_up ? (b2.cnt < b2.cnt_max ? b2.cnt + 9'd1 : b2.cnt)
                                              : (b2.cnt > b2.cnt_min ? b2.cnt - 9'd1 : b2.cnt);
    end
  end

  int en1 = 0, run1 = 0, to1 = 0, en2 = 0, to2 = 0;
  always @(posedge clk) begin
    if (b1.cnt_en)       en1  <= en1 + 1;
    if (b1.state == 3'd2) run1 <= run1 + 1;
    if (b1.timeout)      to1  <= to1 + 1;
    if (b2.cnt_en)       en2  <= en2 + 1;
    if (b2.timeout)      to2  <= to2 + 1;
  end

  int vectors = 0, miscompares = 0;
  int t = 0;
  int en_q[$];
  int to_q[$];
  // Round-level model: mode, load cycles remaining, RUN cycles elapsed this round.
  int m = 0, ll = 0, rc = 0, first = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0d expected=%0d (t=%0d)", tag, obs, exp, t);
    end
  endtask

  task automatic step(input int s, input int p, input int k, input int r);
    int e_en, e_ld, e_busy, e_to;
    int nm, nll, nrc, nfirst;
    b0.start = (s != 0); b0.pause = (p != 0); b0.stop = (k != 0); rst = (r != 0);
    #1;
    e_en   = (m == 2 && k == 0 && (rc % TICK) == TICK - 1 && b0.cnt != 9'(ENDV)) ? 1 : 0;
    e_ld   = (m == 1 && k == 0) ? 1 : 0;
    e_busy = (m >= 1 && m <= 3) ? 1 : 0;
    e_to   = (m == 4 && first != 0) ? 1 : 0;
    chk("state",    32'(b0.state),    m);
    chk("cnt_en",   32'(b0.cnt_en),   e_en);
    chk("cnt_load", 32'(b0.cnt_load), e_ld);
    chk("busy",     32'(b0.busy),     e_busy);
    chk("timeout",  32'(b0.timeout),  e_to);
    if (b0.cnt_en === 1'b1)  en_q.push_back(t);
    if (b0.timeout === 1'b1) to_q.push_back(t);
    nm = m; nll = ll; nrc = rc; nfirst = 0;
    if (r != 0 || k != 0) nm = 0;
    else case (m)
      0: if (s != 0) begin nm = 1; nll = LH; end
      1: begin nll = ll - 1; if (nll == 0) begin nm = 2; nrc = 0; end end
      2: begin
           nrc = rc + 1;
           if (s != 0) begin nm = 1; nll = LH; end
           else if (b0.cnt == 9'(ENDV)) begin nm = 4; nfirst = 1; end
           else if (p != 0) nm = 3;
         end
      3: if (s != 0) begin nm = 1; nll = LH; end else if (p == 0) nm = 2;
      4: if (s != 0) begin nm = 1; nll = LH; end
      default: nm = 0;
    endcase
    @(posedge clk);
    m = nm; ll = nll; rc = nrc; first = nfirst;
    @(negedge clk);
    t++;
  endtask

  task automatic run(input int n, input int s, input int p, input int k, input int r);
    for (int i = 0; i < n; i++) step(s, p, k, r);
  endtask

  task automatic scen_begin();
    en_q.delete(); to_q.delete(); t = 0;
  endtask

  initial begin
    b0.start = 0; b0.pause = 0; b0.stop = 0;
    b1.start = 0; b1.pause = 0; b1.stop = 0;
    b2.start = 0; b2.pause = 0; b2.stop = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("cnt_up",   32'(b0.cnt_up), 0);
    chk("load_val", 32'(b0.cnt_load_value), 3);
    chk("cnt_max",  32'(b0.cnt_max), 3);
    chk("cnt_min",  32'(b0.cnt_min), 0);
    run(1, 0, 0, 0, 1);

    // Equal-value and up-counting instances.
    b1.start = 1; b2.start = 1;
    run(1, 0, 0, 0, 0);
    b1.start = 0; b2.start = 0;
    run(59, 0, 0, 0, 0);
    chk("eq_run_cycles", run1, 1);
    chk("eq_enables",    en1, 0);
    chk("eq_timeouts",   to1, 1);
    chk("eq_state",      32'(b1.state), 4);
    chk("up_dir",        32'(b2.cnt_up), 1);
    chk("up_max",        32'(b2.cnt_max), 9);
    chk("up_min",        32'(b2.cnt_min), 0);
    chk("up_enables",    en2, 9);
    chk("up_timeouts",   to2, 1);
    chk("up_final_cnt",  32'(b2.cnt), 9);

    // Basic round.
    scen_begin();
    run(1, 1, 0, 0, 0);
    run(19, 0, 0, 0, 0);
    chk("basic_en_n", en_q.size(), 3);
    if (en_q.size() == 3) begin
      chk("basic_en0", en_q[0], 7); chk("basic_en1", en_q[1], 11); chk("basic_en2", en_q[2], 15);
    end
    chk("basic_to_n", to_q.size(), 1);
    if (to_q.size() == 1) chk("basic_to_t", to_q[0], 17);
    run(1, 0, 0, 1, 0);

    // Pause cycles 9..20.
    scen_begin();
    run(1, 1, 0, 0, 0);
    run(8, 0, 0, 0, 0);
    run(12, 0, 1, 0, 0);
    run(11, 0, 0, 0, 0);
    chk("pause_en_n", en_q.size(), 3);
    if (en_q.size() == 3) begin
      chk("pause_en0", en_q[0], 7); chk("pause_en1", en_q[1], 23); chk("pause_en2", en_q[2], 27);
    end
    chk("pause_to_n", to_q.size(), 1);
    if (to_q.size() == 1) chk("pause_to_t", to_q[0], 29);
    run(1, 0, 0, 1, 0);

    // Stop wins over start.
    scen_begin();
    run(1, 1, 0, 0, 0);
    run(11, 0, 0, 0, 0);
    run(1, 1, 0, 1, 0);
    chk("stop_state", 32'(b0.state), 0);
    run(8, 0, 0, 0, 0);
    chk("stop_to_n", to_q.size(), 0);

    // Restart from RUN.
    scen_begin();
    run(1, 1, 0, 0, 0);
    run(8, 0, 0, 0, 0);
    chk("restart_pre_cnt", 32'(b0.cnt), 2);
    run(1, 1, 0, 0, 0);
    run(2, 0, 0, 0, 0);
    chk("restart_cnt", 32'(b0.cnt), 3);
    run(1, 0, 0, 1, 0);

    // Reset mid-round.
    scen_begin();
    run(1, 1, 0, 0, 0);
    run(4, 0, 0, 0, 0);
    run(1, 0, 0, 0, 1);
    chk("rst_state", 32'(b0.state), 0);
    chk("rst_busy",  32'(b0.busy), 0);
    run(3, 0, 0, 0, 0);

    // Random command traffic.
    begin
      int p = 0;
      for (int i = 0; i < 600; i++) begin
        if ($urandom % 8 == 0) p = 1 - p;
        step(($urandom % 12 == 0) ? 1 : 0, p, ($urandom % 40 == 0) ? 1 : 0,
             ($urandom % 90 == 0) ? 1 : 0);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
